// File: rtl/memory_bus_router_pkg.sv
// Shared types and helpers for the memory bus router and its wait/timeout timer.
package memory_bus_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  localparam logic [7:0] ERROR_DATA_DEFAULT = 8'hff;

  // Width of the region index field; a single region still needs one bit.
  function automatic int region_idx_width(input int num_regions);
    int w;
    w = 0;
    while ((1 << w) < num_regions) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/memory_bus_router_timer.sv
// Wait-state countdown followed by a busy-timeout counter for one outstanding access.
module bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       run_i,
  input  logic       busy_i,
  input  logic [3:0] load_value_i,
  output logic       expired_o,
  output logic       timeout_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] busy_cnt_q, busy_cnt_d;

  // The launch cycle already consumed one wait state, so a count of one is the last.
  assign expired_o = (wait_cnt_q <= 4'd1);
  assign timeout_o = (TIMEOUT_CYCLES != 0) && run_i && expired_o && busy_i &&
                     (busy_cnt_q == TimeoutLast);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    busy_cnt_d = busy_cnt_q;
    if (load_i) begin
      wait_cnt_d = load_value_i;
      busy_cnt_d = '0;
    end else if (run_i) begin
      if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
      if (expired_o && busy_i && (busy_cnt_q != 8'hff)) busy_cnt_d = busy_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = '0;
      busy_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

// File: rtl/memory_bus_router.sv
// Decodes the CPU address into a region and routes strobes, read data and halt,
// adding programmable wait states, busy timeout and unmapped-region errors.
module memory_bus_router
  import memory_bus_router_pkg::*;
#(
  parameter int                          ADDR_WIDTH     = 24,
  parameter int                          DATA_WIDTH     = 8,
  parameter int                          NUM_REGIONS    = 4,
  parameter int                          REGION_SHIFT   = 14,
  parameter int                          FAR_REGION     = 3,
  parameter logic [NUM_REGIONS-1:0]      REGION_MAP     = {NUM_REGIONS{1'b1}},
  parameter logic [4*NUM_REGIONS-1:0]    WAIT_STATES    = '0,
  parameter int                          TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]       ERROR_DATA     = DATA_WIDTH'(ERROR_DATA_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  input  logic                              bus_enable,
  input  logic                              write_enable,
  output logic                              bus_halt,
  output logic                              bus_error,
  output logic [ADDR_WIDTH-1:0]             error_address,
  output logic [NUM_REGIONS-1:0]            region_enable,
  output logic [NUM_REGIONS-1:0]            region_write_enable,
  output logic [DATA_WIDTH-1:0]             region_data_in,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_data_out,
  input  logic [NUM_REGIONS-1:0]            region_busy
);

  localparam int IDX_W     = region_idx_width(NUM_REGIONS);
  localparam int FIELD_TOP = REGION_SHIFT + IDX_W;

  bus_state_e             state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic [IDX_W-1:0]       sel;
  logic                   far_hit;
  logic                   mapped;
  logic [3:0]             sel_waits;
  logic [3:0]             load_value;
  logic [NUM_REGIONS-1:0] sel_hot, sel_q_hot;
  logic                   timer_load, timer_run;
  logic                   wait_expired, wait_timeout;
  logic [DATA_WIDTH-1:0]  rdata_arr [NUM_REGIONS];

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_rdata
    assign rdata_arr[i] = region_data_out[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign region_data_in = data_in;
  assign error_address  = err_addr_q;

  // Any set bit above the index field means the access targets the far region.
  assign far_hit    = |address[ADDR_WIDTH-1:FIELD_TOP];
  assign sel        = far_hit ? IDX_W'(FAR_REGION) : address[REGION_SHIFT +: IDX_W];
  assign mapped     = (int'(sel) < NUM_REGIONS) && REGION_MAP[sel];
  assign sel_waits  = WAIT_STATES[{sel, 2'b00} +: 4];
  assign load_value = (sel_waits == 4'd0) ? 4'd0 : sel_waits - 4'd1;
  assign sel_hot    = NUM_REGIONS'(1) << sel;
  assign sel_q_hot  = NUM_REGIONS'(1) << sel_q;

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (timer_load),
    .run_i       (timer_run),
    .busy_i      (region_busy[sel_q]),
    .load_value_i(load_value),
    .expired_o   (wait_expired),
    .timeout_o   (wait_timeout)
  );

  // Outputs are held at zero while reset is asserted, even with a request pending.
  always_comb begin
    state_d             = state_q;
    sel_d               = sel_q;
    we_d                = we_q;
    err_d               = err_q;
    addr_d              = addr_q;
    err_addr_d          = err_addr_q;
    rdata_d             = rdata_q;
    timer_load          = 1'b0;
    timer_run           = 1'b0;
    data_out            = '0;
    bus_halt            = 1'b0;
    bus_error           = 1'b0;
    region_enable       = '0;
    region_write_enable = '0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus_enable) begin
            if (!mapped) begin
              bus_error  = 1'b1;
              data_out   = ERROR_DATA;
              err_addr_d = address;
            end else if ((sel_waits == 4'd0) && !region_busy[sel]) begin
              region_enable       = sel_hot;
              region_write_enable = write_enable ? sel_hot : '0;
              data_out            = rdata_arr[sel];
            end else begin
              sel_d      = sel;
              we_d       = write_enable;
              addr_d     = address;
              err_d      = 1'b0;
              timer_load = 1'b1;
              bus_halt   = 1'b1;
              state_d    = WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus_enable) begin
            state_d = IDLE;
          end else begin
            region_enable = sel_q_hot;
            bus_halt      = 1'b1;
            timer_run     = 1'b1;
            if (wait_expired && !region_busy[sel_q]) begin
              rdata_d = rdata_arr[sel_q];
              state_d = DONE;
            end else if (wait_timeout) begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          region_enable = sel_q_hot;
          if (err_q) begin
            bus_error  = 1'b1;
            data_out   = ERROR_DATA;
            err_addr_d = addr_q;
          end else begin
            data_out            = rdata_q;
            region_write_enable = we_q ? sel_q_hot : '0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      err_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
